// File: rtl/vedic_pkg.sv
// Shared definitions for the vedic_24 datapath: widths, sequencer state
// encoding and the per-step partial-product shift amounts.
// Read by vedic_12 (combinational 12x12 core) and vedic_24_seq (sequencer).
package vedic_pkg;

  // Operand width of the vedic_12 core and default half width of the sequencer
  localparam int unsigned VEDIC12_W      = 12;
  localparam int unsigned HALF_W_DEFAULT = VEDIC12_W;

  // Four partial products: aL*bL, aL*bH, aH*bL, aH*bH
  localparam int unsigned NUM_STEPS = 4;
  localparam int unsigned STEP_W    = 2;

  localparam int unsigned SHIFT_S0 = 0;
  localparam int unsigned SHIFT_S1 = VEDIC12_W;
  localparam int unsigned SHIFT_S2 = VEDIC12_W;
  localparam int unsigned SHIFT_S3 = 2 * VEDIC12_W;

  localparam int unsigned SHIFT_BITS = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Left-shift applied to the partial product issued at a given step
  function automatic logic [SHIFT_BITS-1:0] step_shift(input logic [STEP_W-1:0] step);
    logic [SHIFT_BITS-1:0] sh;
    sh = '0;
    case (step)
      2'd0:    sh = SHIFT_BITS'(SHIFT_S0);
      2'd1:    sh = SHIFT_BITS'(SHIFT_S1);
      2'd2:    sh = SHIFT_BITS'(SHIFT_S2);
      default: sh = SHIFT_BITS'(SHIFT_S3);
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/vedic_12.sv
// Combinational 12x12 unsigned multiplier, Urdhva-Tiryakbhyam form:
// each product column k sums every a[i]&b[j] with i+j==k, then the
// column counts are weighted by 2^k and added.
// Ports: a, b (12-bit operands), p (24-bit product).
module vedic_12
  import vedic_pkg::*;
(
  input  logic [VEDIC12_W-1:0]   a,
  input  logic [VEDIC12_W-1:0]   b,
  output logic [2*VEDIC12_W-1:0] p
);

  localparam int unsigned W     = VEDIC12_W;
  localparam int unsigned PW    = 2 * VEDIC12_W;
  localparam int unsigned COLS  = 2 * VEDIC12_W - 1;
  localparam int unsigned CNT_W = 4;

  // Vertical-and-crosswise column sums, then weighted accumulation
  always_comb begin
    logic [CNT_W-1:0] col [COLS];
    for (int unsigned k = 0; k < COLS; k++) begin
      col[k] = '0;
    end
    for (int unsigned i = 0; i < W; i++) begin
      for (int unsigned j = 0; j < W; j++) begin
        col[i+j] = col[i+j] + CNT_W'(a[i] & b[j]);
      end
    end
    p = '0;
    for (int unsigned k = 0; k < COLS; k++) begin
      p = p + (PW'(col[k]) << k);
    end
  end

endmodule

// File: rtl/vedic_24_seq.sv
// Multi-cycle 24x24 unsigned multiplier sequencer. One vedic_12 core is
// time-shared over four steps; partial products are shifted and summed
// into a 48-bit accumulator. Valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid / in_ready  operand handshake (a, b)
//   out_valid/ out_ready result handshake (p)
//   busy                 sequencer is not idle
// Optional build macro VEDIC_24_SEQ_ZERO_SKIP_EN: a zero operand finishes
// one cycle after acceptance with p=0 instead of running all four steps.
module vedic_24_seq
  import vedic_pkg::*;
#(
  parameter int unsigned HALF_W = HALF_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*HALF_W-1:0] a,
  input  logic [2*HALF_W-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*HALF_W-1:0] p,
  output logic                busy
);

  localparam int unsigned OP_W   = 2 * HALF_W;
  localparam int unsigned PP_W   = 2 * HALF_W;
  localparam int unsigned PROD_W = 4 * HALF_W;

  // The shared core has a fixed operand width
  if (HALF_W != VEDIC12_W) begin : g_bad_half_w
    $error("vedic_24_seq: HALF_W must equal the vedic_12 operand width");
  end

  state_e              r_state, w_state_nxt;
  logic [STEP_W-1:0]   r_step,  w_step_nxt;
  logic [PROD_W-1:0]   r_acc,   w_acc_nxt;
  logic [PROD_W-1:0]   r_p,     w_p_nxt;
  logic                r_out_valid, w_out_valid_nxt;
  logic                r_in_ready,  w_in_ready_nxt;
  logic                r_busy,      w_busy_nxt;
  logic [OP_W-1:0]     r_a, w_a_nxt;
  logic [OP_W-1:0]     r_b, w_b_nxt;
`ifdef VEDIC_24_SEQ_ZERO_SKIP_EN
  logic                r_zero, w_zero_nxt;
`endif

  logic [HALF_W-1:0]   w_a_half;
  logic [HALF_W-1:0]   w_b_half;
  logic [PP_W-1:0]     w_pp;
  logic [PROD_W-1:0]   w_term;
  logic [PROD_W-1:0]   w_sum;

  // Step bit 1 picks the a half, bit 0 the b half: LL, LH, HL, HH
  assign w_a_half = r_step[1] ? r_a[OP_W-1:HALF_W] : r_a[HALF_W-1:0];
  assign w_b_half = r_step[0] ? r_b[OP_W-1:HALF_W] : r_b[HALF_W-1:0];

  vedic_12 u_vedic_12 (
    .a (w_a_half),
    .b (w_b_half),
    .p (w_pp)
  );

  assign w_term = PROD_W'(w_pp) << step_shift(r_step);
  assign w_sum  = r_acc + w_term;

  // Next-state and next-datapath values
  always_comb begin
    w_state_nxt     = r_state;
    w_step_nxt      = r_step;
    w_acc_nxt       = r_acc;
    w_p_nxt         = r_p;
    w_out_valid_nxt = r_out_valid;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
`ifdef VEDIC_24_SEQ_ZERO_SKIP_EN
    w_zero_nxt      = r_zero;
`endif

    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_a_nxt     = a;
          w_b_nxt     = b;
          w_acc_nxt   = '0;
          w_step_nxt  = '0;
          w_state_nxt = MUL;
`ifdef VEDIC_24_SEQ_ZERO_SKIP_EN
          w_zero_nxt  = (a == '0) || (b == '0);
`endif
        end
      end

      MUL: begin
        w_acc_nxt = w_sum;
        if (r_step == STEP_W'(NUM_STEPS - 1)) begin
          w_p_nxt         = w_sum;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = DONE;
        end else begin
          w_step_nxt = r_step + STEP_W'(1);
        end
`ifdef VEDIC_24_SEQ_ZERO_SKIP_EN
        // Known-zero product: skip the remaining steps
        if (r_zero && (r_step == '0)) begin
          w_p_nxt         = '0;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = DONE;
        end
`endif
      end

      DONE: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end

      default: begin
        w_state_nxt     = IDLE;
        w_out_valid_nxt = 1'b0;
      end
    endcase

    w_in_ready_nxt = (w_state_nxt == IDLE);
    w_busy_nxt     = (w_state_nxt != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_step      <= '0;
      r_acc       <= '0;
      r_p         <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
`ifdef VEDIC_24_SEQ_ZERO_SKIP_EN
      r_zero      <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_step      <= w_step_nxt;
      r_acc       <= w_acc_nxt;
      r_p         <= w_p_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
`ifdef VEDIC_24_SEQ_ZERO_SKIP_EN
      r_zero      <= w_zero_nxt;
`endif
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign p         = r_p;
  assign busy      = r_busy;

endmodule

// File: tb/tb_vedic_24_seq.sv
// Directed testbench for vedic_24_seq: reset values, corner products,
// latency, backpressure, mid-operation reset, zero operands and a
// random sweep against a reference multiply.
module tb_vedic_24_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] a;
  logic [23:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] p;
  logic        busy;

  int errors;
  int checks;

`ifdef VEDIC_24_SEQ_ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 4;
`endif

  vedic_24_seq #(.HALF_W(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation, measure latency, check product, then hand it off
  task automatic run_op(input string tag, input logic [23:0] ta, input logic [23:0] tb_,
                        input logic [47:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    a        = ta;
    b        = tb_;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_lat"}, 48'(lat), 48'(exp_lat));
    chk({tag, "_p"}, p, exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_ov_clr"}, 48'(out_valid), 48'd0);
    chk({tag, "_rdy"}, 48'(in_ready), 48'd1);
  endtask

  initial begin
    logic [23:0] ra;
    logic [23:0] rb;
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    // Reset values on the first cycle after release
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("rst_p", p, 48'd0);
    chk("rst_ov", 48'(out_valid), 48'd0);
    chk("rst_busy", 48'(busy), 48'd0);
    chk("rst_rdy", 48'(in_ready), 48'd1);

    // Corner products, each half-product path exercised in isolation
    run_op("max",     24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 4);
    run_op("cross1",  24'h001001, 24'h001001, 48'h000001002001, 4);
    run_op("cross2",  24'h000FFF, 24'hFFF000, 48'h000FFE001000, 4);
    run_op("ll_only", 24'h000FFF, 24'h000FFF, 48'h000000FFE001, 4);
    run_op("hl_only", 24'hFFF000, 24'h000FFF, 48'h000FFE001000, 4);
    run_op("hh_only", 24'hFFF000, 24'hFFF000, 48'hFFE001000000, 4);
    run_op("one",     24'hFFFFFF, 24'h000001, 48'h000000FFFFFF, 4);

    // Backpressure: result held, new operands refused
    @(negedge clk);
    a = 24'd2; b = 24'd3; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("bp_busy", 48'(busy), 48'd1);
    chk("bp_rdy_mul", 48'(in_ready), 48'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_ov", 48'(out_valid), 48'd1);
    a = 24'd7; b = 24'd9; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_p", p, 48'd6);
      chk("bp_hold_ov", 48'(out_valid), 48'd1);
      chk("bp_hold_rdy", 48'(in_ready), 48'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp_release_ov", 48'(out_valid), 48'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("bp_no_queue_ov", 48'(out_valid), 48'd0);
    chk("bp_no_queue_busy", 48'(busy), 48'd0);
    chk("bp_no_queue_p", p, 48'd6);

    // Reset during step 2 discards the in-flight product
    @(negedge clk);
    a = 24'hFFFFFF; b = 24'hFFFFFF; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_p", p, 48'd0);
    chk("mid_rst_ov", 48'(out_valid), 48'd0);
    chk("mid_rst_busy", 48'(busy), 48'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_ov", 48'(out_valid), 48'd0);
    run_op("post_rst", 24'd3, 24'd5, 48'd15, 4);

    // Zero operands
    run_op("zero_a", 24'h000000, 24'h000005, 48'd0, ZERO_LAT);
    run_op("zero_b", 24'hABCDEF, 24'h000000, 48'd0, ZERO_LAT);
    run_op("after_zero", 24'h001000, 24'h001000, 48'h000001000000, 4);

    // Random sweep against the reference product
    for (int i = 0; i < 1000; i++) begin
      ra = 24'($urandom);
      rb = 24'($urandom);
      if (i % 50 == 0) ra = '0;
      run_op("rand", ra, rb, 48'(ra) * 48'(rb),
             ((ra == '0) || (rb == '0)) ? ZERO_LAT : 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
